// File: rtl/multicycle_controller.sv
// Multicycle RV32I control unit: Moore sequencer sharing one ALU and one unified memory,
// with memory-ready stalls, full branch compare and illegal-instruction trapping.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// FETCH    | read instruction at PC, PC <= PC+4 once memory is ready
// DECODE   | classify opcode, branch/jal target (OldPC+imm) into ALUOut
// MEMADR   | rs1+imm effective address for lw/sw
// MEMREAD  | load access, hold until memory ready
// MEMWB    | write loaded data to rd
// MEMWRITE | store access, write enable held until memory ready
// EXECR    | register-register ALU op
// EXECI    | register-immediate ALU op
// ALUWB    | write ALUOut to rd
// BRANCH   | rs1-rs2 compare, PC <= target when taken
// JAL      | PC <= target, ALUOut <= OldPC+4 for the link write
// ILLEGAL  | unsupported encoding, parked until reset

module multicycle_controller #(
   parameter int ALUCTRL_W    = 3,
   parameter bit WAIT_MEM     = 1'b1,
   parameter bit TRAP_ILLEGAL = 1'b1
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic [6:0]           i_op,
   input  logic [2:0]           i_funct3,
   input  logic                 i_funct7b5,
   input  logic                 i_zero,
   input  logic                 i_lt,
   input  logic                 i_ltu,
   input  logic                 i_mem_ready,
   output logic                 o_pcwrite,
   output logic                 o_adrsrc,
   output logic                 o_memwrite,
   output logic                 o_irwrite,
   output logic                 o_regwrite,
   output logic [1:0]           o_resultsrc,
   output logic [1:0]           o_alusrca,
   output logic [1:0]           o_alusrcb,
   output logic [2:0]           o_immsrc,
   output logic [ALUCTRL_W-1:0] o_alucrtl,
   output logic                 o_illegal
);

   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;
   localparam logic [6:0] OP_R     = 7'b0110011;
   localparam logic [6:0] OP_I     = 7'b0010011;
   localparam logic [6:0] OP_B     = 7'b1100011;
   localparam logic [6:0] OP_JAL   = 7'b1101111;

   localparam logic [2:0] ALU_ADD  = 3'b000;
   localparam logic [2:0] ALU_SUB  = 3'b001;
   localparam logic [2:0] ALU_AND  = 3'b010;
   localparam logic [2:0] ALU_OR   = 3'b011;
   localparam logic [2:0] ALU_XOR  = 3'b100;
   localparam logic [2:0] ALU_SLT  = 3'b101;
   localparam logic [2:0] ALU_SLTU = 3'b110;

   typedef enum logic [3:0] {
      S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
      S_EXECR, S_EXECI, S_ALUWB, S_BRANCH, S_JAL, S_ILLEGAL
   } state_t;

   state_t     r_state;
   state_t     w_next;
   logic       w_rdy;
   logic       w_is_load, w_is_store, w_is_r, w_is_i, w_is_b, w_is_jal;
   logic       w_bad;
   logic       w_taken;
   logic [2:0] w_alu_dec;
   logic [2:0] w_alu;
   logic [2:0] w_immsrc;

   assign w_rdy      = i_mem_ready | !WAIT_MEM;
   assign w_is_load  = (i_op == OP_LOAD);
   assign w_is_store = (i_op == OP_STORE);
   assign w_is_r     = (i_op == OP_R);
   assign w_is_i     = (i_op == OP_I);
   assign w_is_b     = (i_op == OP_B);
   assign w_is_jal   = (i_op == OP_JAL);

   // No shifter in the datapath, so shift encodings trap along with unknown ops
   assign w_bad = !(w_is_load | w_is_store | w_is_r | w_is_i | w_is_b | w_is_jal)
                | ((w_is_r | w_is_i) & ((i_funct3 == 3'b001) | (i_funct3 == 3'b101)))
                | (w_is_b & ((i_funct3 == 3'b010) | (i_funct3 == 3'b011)))
                | ((w_is_load | w_is_store) & (i_funct3 != 3'b010));

   always_comb begin
      w_alu_dec = ALU_ADD;
      case (i_funct3)
         3'b000:  w_alu_dec = (w_is_r & i_funct7b5) ? ALU_SUB : ALU_ADD;
         3'b010:  w_alu_dec = ALU_SLT;
         3'b011:  w_alu_dec = ALU_SLTU;
         3'b100:  w_alu_dec = ALU_XOR;
         3'b110:  w_alu_dec = ALU_OR;
         3'b111:  w_alu_dec = ALU_AND;
         default: w_alu_dec = ALU_ADD;
      endcase
   end

   always_comb begin
      w_taken = 1'b0;
      case (i_funct3)
         3'b000:  w_taken = i_zero;
         3'b001:  w_taken = !i_zero;
         3'b100:  w_taken = i_lt;
         3'b101:  w_taken = !i_lt;
         3'b110:  w_taken = i_ltu;
         3'b111:  w_taken = !i_ltu;
         default: w_taken = 1'b0;
      endcase
   end

   always_comb begin
      w_immsrc = 3'b000;
      if (w_is_store)    w_immsrc = 3'b001;
      else if (w_is_b)   w_immsrc = 3'b010;
      else if (w_is_jal) w_immsrc = 3'b011;
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) r_state <= S_FETCH;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next      = r_state;
      o_pcwrite   = 1'b0;
      o_adrsrc    = 1'b0;
      o_memwrite  = 1'b0;
      o_irwrite   = 1'b0;
      o_regwrite  = 1'b0;
      o_resultsrc = 2'b00;
      o_alusrca   = 2'b00;
      o_alusrcb   = 2'b00;
      o_illegal   = 1'b0;
      o_immsrc    = w_immsrc;
      w_alu       = ALU_ADD;
      case (r_state)
         S_FETCH: begin
            o_alusrcb   = 2'b10;
            o_resultsrc = 2'b10;
            o_irwrite   = w_rdy;
            o_pcwrite   = w_rdy;
            if (w_rdy) w_next = S_DECODE;
         end
         S_DECODE: begin
            o_alusrca = 2'b01;
            o_alusrcb = 2'b01;
            if (w_bad)                        w_next = TRAP_ILLEGAL ? S_ILLEGAL : S_FETCH;
            else if (w_is_load | w_is_store)  w_next = S_MEMADR;
            else if (w_is_r)                  w_next = S_EXECR;
            else if (w_is_i)                  w_next = S_EXECI;
            else if (w_is_b)                  w_next = S_BRANCH;
            else                              w_next = S_JAL;
         end
         S_MEMADR: begin
            o_alusrca = 2'b10;
            o_alusrcb = 2'b01;
            w_next    = w_is_store ? S_MEMWRITE : S_MEMREAD;
         end
         S_MEMREAD: begin
            o_adrsrc = 1'b1;
            if (w_rdy) w_next = S_MEMWB;
         end
         S_MEMWB: begin
            o_resultsrc = 2'b01;
            o_regwrite  = 1'b1;
            w_next      = S_FETCH;
         end
         S_MEMWRITE: begin
            o_adrsrc   = 1'b1;
            o_memwrite = 1'b1;
            if (w_rdy) w_next = S_FETCH;
         end
         S_EXECR: begin
            o_alusrca = 2'b10;
            o_alusrcb = 2'b00;
            w_alu     = w_alu_dec;
            w_next    = S_ALUWB;
         end
         S_EXECI: begin
            o_alusrca = 2'b10;
            o_alusrcb = 2'b01;
            w_alu     = w_alu_dec;
            w_next    = S_ALUWB;
         end
         S_ALUWB: begin
            o_regwrite = 1'b1;
            w_next     = S_FETCH;
         end
         S_BRANCH: begin
            o_alusrca = 2'b10;
            o_alusrcb = 2'b00;
            w_alu     = ALU_SUB;
            o_pcwrite = w_taken;
            w_next    = S_FETCH;
         end
         S_JAL: begin
            o_alusrca = 2'b01;
            o_alusrcb = 2'b10;
            o_pcwrite = 1'b1;
            w_next    = S_ALUWB;
         end
         S_ILLEGAL: begin
            o_illegal = 1'b1;
         end
         default: w_next = S_FETCH;
      endcase

      o_alucrtl      = '0;
      o_alucrtl[2:0] = w_alu;

      // Reset squelches every output so an aborted instruction cannot write
      if (i_rst) begin
         o_pcwrite   = 1'b0;
         o_adrsrc    = 1'b0;
         o_memwrite  = 1'b0;
         o_irwrite   = 1'b0;
         o_regwrite  = 1'b0;
         o_resultsrc = 2'b00;
         o_alusrca   = 2'b00;
         o_alusrcb   = 2'b00;
         o_immsrc    = 3'b000;
         o_alucrtl   = '0;
         o_illegal   = 1'b0;
      end
   end

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: per-cycle sequences for stalls/reset/trap,
// plus an instruction table whose expected latency and enable counts go through a scoreboard.

module tb_multicycle_controller;

   logic       clk = 1'b0;
   logic       i_rst = 1'b1;
   logic [6:0] i_op = 7'b0110011;
   logic [2:0] i_funct3 = 3'b000;
   logic       i_funct7b5 = 1'b0;
   logic       i_zero = 1'b0, i_lt = 1'b0, i_ltu = 1'b0;
   logic       i_mem_ready = 1'b1;
   logic       u1_ready = 1'b0;

   logic       pcwrite, adrsrc, memwrite, irwrite, regwrite, illegal;
   logic [1:0] resultsrc, alusrca, alusrcb;
   logic [2:0] immsrc, alucrtl;

   logic       u1_pcwrite, u1_adrsrc, u1_memwrite, u1_irwrite, u1_regwrite, u1_illegal;
   logic [1:0] u1_resultsrc, u1_alusrca, u1_alusrcb;
   logic [2:0] u1_immsrc, u1_alucrtl;

   always #5 clk = ~clk;

   multicycle_controller u0 (
      .i_clk(clk), .i_rst(i_rst), .i_op(i_op), .i_funct3(i_funct3), .i_funct7b5(i_funct7b5),
      .i_zero(i_zero), .i_lt(i_lt), .i_ltu(i_ltu), .i_mem_ready(i_mem_ready),
      .o_pcwrite(pcwrite), .o_adrsrc(adrsrc), .o_memwrite(memwrite), .o_irwrite(irwrite),
      .o_regwrite(regwrite), .o_resultsrc(resultsrc), .o_alusrca(alusrca), .o_alusrcb(alusrcb),
      .o_immsrc(immsrc), .o_alucrtl(alucrtl), .o_illegal(illegal)
   );

   // Non-trapping, non-stalling variant; its ready input is held low on purpose
   multicycle_controller #(.WAIT_MEM(1'b0), .TRAP_ILLEGAL(1'b0)) u1 (
      .i_clk(clk), .i_rst(i_rst), .i_op(i_op), .i_funct3(i_funct3), .i_funct7b5(i_funct7b5),
      .i_zero(i_zero), .i_lt(i_lt), .i_ltu(i_ltu), .i_mem_ready(u1_ready),
      .o_pcwrite(u1_pcwrite), .o_adrsrc(u1_adrsrc), .o_memwrite(u1_memwrite), .o_irwrite(u1_irwrite),
      .o_regwrite(u1_regwrite), .o_resultsrc(u1_resultsrc), .o_alusrca(u1_alusrca), .o_alusrcb(u1_alusrcb),
      .o_immsrc(u1_immsrc), .o_alucrtl(u1_alucrtl), .o_illegal(u1_illegal)
   );

   logic [17:0] vec;
   assign vec = {pcwrite, adrsrc, memwrite, irwrite, regwrite, resultsrc,
                 alusrca, alusrcb, immsrc, alucrtl, illegal};

   int checks = 0;
   int failures = 0;

   typedef struct {
      logic [6:0] op; logic [2:0] f3; logic f7; logic z, lt, ltu;
      int lat, pc, rw, mw; logic [2:0] alu; logic ill;
   } vec_t;

   typedef struct { logic rst, rdy; logic [17:0] exp; int u1_ir; } step_t;

   vec_t  tbl[$];
   vec_t  sb[$];
   step_t seq[$];

   function automatic vec_t mk(logic [6:0] op, logic [2:0] f3, logic f7, logic z, logic lt,
                               logic ltu, int lat, int pc, int rw, int mw, logic [2:0] alu, logic ill);
      vec_t v;
      v.op = op; v.f3 = f3; v.f7 = f7; v.z = z; v.lt = lt; v.ltu = ltu;
      v.lat = lat; v.pc = pc; v.rw = rw; v.mw = mw; v.alu = alu; v.ill = ill;
      return v;
   endfunction

   function automatic logic [17:0] ov(logic pc, logic ad, logic mw, logic ir, logic rw,
                                      logic [1:0] rs, logic [1:0] a, logic [1:0] b,
                                      logic [2:0] imm, logic [2:0] alu, logic il);
      return {pc, ad, mw, ir, rw, rs, a, b, imm, alu, il};
   endfunction

   function automatic logic [17:0] f_fetch(logic [2:0] imm);
      return ov(1, 0, 0, 1, 0, 2'b10, 2'b00, 2'b10, imm, 3'b000, 0);
   endfunction

   function automatic logic [17:0] f_dec(logic [2:0] imm);
      return ov(0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, imm, 3'b000, 0);
   endfunction

   function automatic step_t st(logic rst, logic rdy, logic [17:0] e, int u1);
      step_t s;
      s.rst = rst; s.rdy = rdy; s.exp = e; s.u1_ir = u1;
      return s;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Inputs for a cycle are applied at its falling edge; outputs are sampled 1ns later
   task automatic cyc(input logic rst, input logic rdy);
      @(negedge clk);
      i_rst = rst;
      i_mem_ready = rdy;
      #1;
   endtask

   task automatic run_seq(input string name);
      for (int i = 0; i < seq.size(); i++) begin
         cyc(seq[i].rst, seq[i].rdy);
         check($sformatf("%s[%0d]", name, i), 32'(vec), 32'(seq[i].exp));
         if (seq[i].u1_ir >= 0) begin
            check($sformatf("%s_u1ir[%0d]", name, i), 32'(u1_irwrite), 32'(seq[i].u1_ir));
            check($sformatf("%s_u1ill[%0d]", name, i), 32'(u1_illegal), 32'd0);
         end
      end
      seq.delete();
   endtask

   task automatic set_ir(input logic [6:0] op, input logic [2:0] f3, input logic f7);
      i_op = op; i_funct3 = f3; i_funct7b5 = f7;
   endtask

   // Entered mid-FETCH (already sampled); returns mid-FETCH of the following instruction
   task automatic run_instr(input int idx, input vec_t v);
      int   k, pc, rw, mw;
      logic [2:0] alu;
      logic ill, done;
      vec_t e;
      k = 0; pc = 0; rw = 0; mw = 0; alu = 3'b000; ill = 1'b0; done = 1'b0;
      sb.push_back(v);
      set_ir(v.op, v.f3, v.f7);
      i_zero = v.z; i_lt = v.lt; i_ltu = v.ltu;
      while (!done && k < 20) begin
         cyc(1'b0, 1'b1);
         k++;
         if (illegal) begin
            ill = 1'b1; done = 1'b1;
         end else if (irwrite) begin
            done = 1'b1;
         end else begin
            pc += int'(pcwrite); rw += int'(regwrite); mw += int'(memwrite);
            alu |= alucrtl;
         end
      end
      if (!done) begin
         checks++; failures++;
         $display("FAIL tbl%0d_timeout: no return to FETCH within 20 cycles", idx);
      end
      e = sb.pop_front();
      check($sformatf("tbl%0d_lat", idx), 32'(k), 32'(e.lat));
      check($sformatf("tbl%0d_pcwrite", idx), 32'(pc), 32'(e.pc));
      check($sformatf("tbl%0d_regwrite", idx), 32'(rw), 32'(e.rw));
      check($sformatf("tbl%0d_memwrite", idx), 32'(mw), 32'(e.mw));
      check($sformatf("tbl%0d_alu", idx), 32'(alu), 32'(e.alu));
      check($sformatf("tbl%0d_illegal", idx), 32'(ill), 32'(e.ill));
      if (ill) begin
         for (int j = 0; j < 3; j++) begin
            cyc(1'b0, j[0]);
            check($sformatf("tbl%0d_stuck_ill", idx), 32'(illegal), 32'd1);
            check($sformatf("tbl%0d_stuck_en", idx), 32'({pcwrite, memwrite, irwrite, regwrite}), 32'd0);
         end
         cyc(1'b1, 1'b1);
         cyc(1'b0, 1'b1);
         check($sformatf("tbl%0d_refetch", idx), 32'(irwrite), 32'd1);
      end
   endtask

   localparam logic [6:0] R = 7'b0110011, I = 7'b0010011, LW = 7'b0000011;
   localparam logic [6:0] SW = 7'b0100011, B = 7'b1100011, J = 7'b1101111;

   initial begin
      // add with a reset pulse mid-EXECR, then a clean add
      set_ir(R, 3'b000, 1'b0);
      seq.push_back(st(1, 1, 18'd0, -1));
      seq.push_back(st(0, 1, f_fetch(3'b000), -1));
      seq.push_back(st(0, 1, f_dec(3'b000), -1));
      seq.push_back(st(1, 1, 18'd0, -1));
      seq.push_back(st(0, 1, f_fetch(3'b000), -1));
      seq.push_back(st(0, 1, f_dec(3'b000), -1));
      seq.push_back(st(0, 1, ov(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b000, 3'b000, 0), -1));
      seq.push_back(st(0, 1, ov(0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 0), -1));
      seq.push_back(st(0, 1, f_fetch(3'b000), -1));
      run_seq("add_rst");

      // lw with two wait cycles in FETCH and in MEMREAD: nine cycles, one irwrite
      set_ir(LW, 3'b010, 1'b0);
      seq.push_back(st(1, 1, 18'd0, -1));
      seq.push_back(st(0, 0, ov(0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 3'b000, 3'b000, 0), -1));
      seq.push_back(st(0, 0, ov(0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 3'b000, 3'b000, 0), -1));
      seq.push_back(st(0, 1, f_fetch(3'b000), -1));
      seq.push_back(st(0, 1, f_dec(3'b000), -1));
      seq.push_back(st(0, 1, ov(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 3'b000, 0), -1));
      seq.push_back(st(0, 0, ov(0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 0), -1));
      seq.push_back(st(0, 0, ov(0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 0), -1));
      seq.push_back(st(0, 1, ov(0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 0), -1));
      seq.push_back(st(0, 1, ov(0, 0, 0, 0, 1, 2'b01, 2'b00, 2'b00, 3'b000, 3'b000, 0), -1));
      seq.push_back(st(0, 1, f_fetch(3'b000), -1));
      run_seq("lw_wait");

      // sw with memory ready on the third MEMWRITE cycle
      set_ir(SW, 3'b010, 1'b0);
      seq.push_back(st(1, 1, 18'd0, -1));
      seq.push_back(st(0, 1, f_fetch(3'b001), -1));
      seq.push_back(st(0, 1, f_dec(3'b001), -1));
      seq.push_back(st(0, 1, ov(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b001, 3'b000, 0), -1));
      seq.push_back(st(0, 0, ov(0, 1, 1, 0, 0, 2'b00, 2'b00, 2'b00, 3'b001, 3'b000, 0), -1));
      seq.push_back(st(0, 0, ov(0, 1, 1, 0, 0, 2'b00, 2'b00, 2'b00, 3'b001, 3'b000, 0), -1));
      seq.push_back(st(0, 1, ov(0, 1, 1, 0, 0, 2'b00, 2'b00, 2'b00, 3'b001, 3'b000, 0), -1));
      seq.push_back(st(0, 1, f_fetch(3'b001), -1));
      run_seq("sw_wait");

      // opcode 0x7F: trapping instance parks, non-trapping one keeps fetching
      set_ir(7'h7F, 3'b000, 1'b0);
      seq.push_back(st(1, 1, 18'd0, 0));
      seq.push_back(st(0, 1, f_fetch(3'b000), 1));
      seq.push_back(st(0, 1, f_dec(3'b000), 0));
      seq.push_back(st(0, 1, ov(0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 1), 1));
      seq.push_back(st(0, 0, ov(0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 1), 0));
      seq.push_back(st(0, 1, ov(0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 1), 1));
      seq.push_back(st(1, 1, 18'd0, 0));
      seq.push_back(st(0, 1, f_fetch(3'b000), 1));
      run_seq("illegal");

      //             op  f3      f7 z  lt ltu lat pc rw mw alu    ill
      tbl.push_back(mk(R,  3'b000, 0, 0, 0, 0, 4, 0, 1, 0, 3'd0, 0));
      tbl.push_back(mk(R,  3'b000, 1, 0, 0, 0, 4, 0, 1, 0, 3'd1, 0));
      tbl.push_back(mk(R,  3'b111, 0, 0, 0, 0, 4, 0, 1, 0, 3'd2, 0));
      tbl.push_back(mk(R,  3'b110, 0, 0, 0, 0, 4, 0, 1, 0, 3'd3, 0));
      tbl.push_back(mk(R,  3'b100, 0, 0, 0, 0, 4, 0, 1, 0, 3'd4, 0));
      tbl.push_back(mk(R,  3'b010, 0, 0, 0, 0, 4, 0, 1, 0, 3'd5, 0));
      tbl.push_back(mk(R,  3'b011, 0, 0, 0, 0, 4, 0, 1, 0, 3'd6, 0));
      tbl.push_back(mk(I,  3'b000, 1, 0, 0, 0, 4, 0, 1, 0, 3'd0, 0));
      tbl.push_back(mk(I,  3'b010, 0, 0, 0, 0, 4, 0, 1, 0, 3'd5, 0));
      tbl.push_back(mk(I,  3'b111, 0, 0, 0, 0, 4, 0, 1, 0, 3'd2, 0));
      tbl.push_back(mk(LW, 3'b010, 0, 0, 0, 0, 5, 0, 1, 0, 3'd0, 0));
      tbl.push_back(mk(SW, 3'b010, 0, 0, 0, 0, 4, 0, 0, 1, 3'd0, 0));
      tbl.push_back(mk(B,  3'b000, 0, 1, 0, 0, 3, 1, 0, 0, 3'd1, 0));
      tbl.push_back(mk(B,  3'b000, 0, 0, 1, 1, 3, 0, 0, 0, 3'd1, 0));
      tbl.push_back(mk(B,  3'b001, 0, 0, 0, 0, 3, 1, 0, 0, 3'd1, 0));
      tbl.push_back(mk(B,  3'b001, 0, 1, 1, 1, 3, 0, 0, 0, 3'd1, 0));
      tbl.push_back(mk(B,  3'b100, 0, 1, 1, 0, 3, 1, 0, 0, 3'd1, 0));
      tbl.push_back(mk(B,  3'b100, 0, 1, 0, 1, 3, 0, 0, 0, 3'd1, 0));
      tbl.push_back(mk(B,  3'b101, 0, 1, 0, 1, 3, 1, 0, 0, 3'd1, 0));
      tbl.push_back(mk(B,  3'b101, 0, 0, 1, 0, 3, 0, 0, 0, 3'd1, 0));
      tbl.push_back(mk(B,  3'b110, 0, 1, 0, 1, 3, 1, 0, 0, 3'd1, 0));
      tbl.push_back(mk(B,  3'b110, 0, 0, 1, 0, 3, 0, 0, 0, 3'd1, 0));
      tbl.push_back(mk(B,  3'b111, 0, 0, 0, 1, 3, 0, 0, 0, 3'd1, 0));
      tbl.push_back(mk(B,  3'b111, 0, 1, 1, 0, 3, 1, 0, 0, 3'd1, 0));
      tbl.push_back(mk(J,  3'b000, 0, 0, 0, 0, 4, 1, 1, 0, 3'd0, 0));
      tbl.push_back(mk(7'h7F, 3'b000, 0, 0, 0, 0, 2, 0, 0, 0, 3'd0, 1));
      tbl.push_back(mk(I,  3'b001, 0, 0, 0, 0, 2, 0, 0, 0, 3'd0, 1));
      tbl.push_back(mk(R,  3'b101, 0, 0, 0, 0, 2, 0, 0, 0, 3'd0, 1));
      tbl.push_back(mk(B,  3'b010, 0, 0, 0, 0, 2, 0, 0, 0, 3'd0, 1));
      tbl.push_back(mk(B,  3'b011, 0, 0, 0, 0, 2, 0, 0, 0, 3'd0, 1));
      tbl.push_back(mk(LW, 3'b000, 0, 0, 0, 0, 2, 0, 0, 0, 3'd0, 1));
      tbl.push_back(mk(SW, 3'b011, 0, 0, 0, 0, 2, 0, 0, 0, 3'd0, 1));

      for (int i = 0; i < tbl.size(); i++) run_instr(i, tbl[i]);

      check("sb_empty", 32'(sb.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", checks, failures);
      $fatal(1);
   end

endmodule
